// File: rtl/crypt_pkg.sv
// -----------------------------------------------------------------------------
// crypt_pkg
// Shared types, memory map constants and helper functions for the LFSR
// encryption sequencer.
//   state_t      : sequencer FSM states
//   lfsr_next    : one Fibonacci-style step of the 8-bit keystream LFSR
//   is_msg_byte  : whether output byte idx is taken from the message area
// -----------------------------------------------------------------------------
package crypt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_PRE  = 3'd1,
    RD_TAP  = 3'd2,
    RD_SEED = 3'd3,
    SRC     = 3'd4,
    WR      = 3'd5,
    FIN     = 3'd6
  } state_t;

  localparam logic [7:0] MSG_BASE = 8'd0;
  localparam logic [7:0] MSG_MAX  = 8'd61;
  localparam logic [7:0] CFG_PRE  = 8'd61;
  localparam logic [7:0] CFG_TAP  = 8'd62;
  localparam logic [7:0] CFG_SEED = 8'd63;
  localparam logic [7:0] OUT_BASE = 8'd64;
  localparam int         NBYTES   = 64;
  localparam logic [7:0] PAD      = 8'h20;

  // Shift left, feeding the parity of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state,
                                           input logic [7:0] tap);
    return {state[6:0], ^(state & tap)};
  endfunction

  // Output byte idx is a message byte when pre <= idx < pre + MSG_MAX.
  function automatic logic is_msg_byte(input logic [6:0] idx,
                                       input logic [7:0] pre);
    logic [7:0] m;
    m = {1'b0, idx} - pre;
    return ({1'b0, idx} >= pre) && (m < MSG_MAX);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit keystream register. load_i has priority over adv_i.
//   clk, reset : clock, synchronous active-high reset (clears state)
//   load_i     : load seed_i
//   seed_i     : starting state
//   adv_i      : advance one step using tap_i
//   tap_i      : tap pattern
//   state_o    : current state
//   next_o     : state the register takes on the next edge
// -----------------------------------------------------------------------------
module lfsr8
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       adv_i,
  input  logic [7:0] tap_i,
  output logic [7:0] state_o,
  output logic [7:0] next_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Next-state selection: load, advance or hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (adv_i) begin
      state_d = lfsr_next(state_q, tap_i);
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 8'h00;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = state_d;

endmodule

// File: rtl/lfsr_crypt_sequencer.sv
// -----------------------------------------------------------------------------
// lfsr_crypt_sequencer
// Reads pre-length, tap and seed from data memory, then writes 64 bytes
// (pre spaces, message, space padding) XORed with an LFSR keystream to
// mem[64..127]. Memory-side outputs are registered: the values for the
// upcoming state are computed one cycle ahead and loaded on the same edge
// that enters that state.
//   clk, reset : clock, synchronous active-high reset
//   start      : job request, sampled in IDLE only
//   busy       : job in progress
//   done       : sticky job-complete flag
//   mem_addr   : memory address (0 when no strobe)
//   mem_rd_en  : read strobe, mem_rdata valid same cycle
//   mem_rdata  : read data
//   mem_wr_en  : write strobe
//   mem_wdata  : write data
// -----------------------------------------------------------------------------
module lfsr_crypt_sequencer
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata
);

  localparam logic [6:0] LAST_IDX = 7'(NBYTES - 1);

  state_t     state_q, state_d;
  logic [6:0] i_q, i_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] tap_q, tap_d;
  logic [7:0] src_q, src_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] addr_q, addr_d;
  logic       rd_en_q, rd_en_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wdata_q, wdata_d;

  logic       enter_byte_s;
  logic [6:0] byte_idx_s;
  logic       lfsr_load_s;
  logic       lfsr_adv_s;
  logic [7:0] lfsr_s;
  logic [7:0] lfsr_nx_s;

  // The seed is captured on the RD_SEED edge; each WR edge steps the keystream.
  assign lfsr_load_s = (state_q == RD_SEED);
  assign lfsr_adv_s  = (state_q == WR);

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lfsr_load_s),
    .seed_i  (mem_rdata),
    .adv_i   (lfsr_adv_s),
    .tap_i   (tap_q),
    .state_o (lfsr_s),
    .next_o  (lfsr_nx_s)
  );

  // Next-state and look-ahead memory-port values.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    pre_d        = pre_q;
    tap_d        = tap_q;
    src_d        = src_q;
    busy_d       = busy_q;
    done_d       = done_q;
    addr_d       = 8'h00;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    wdata_d      = 8'h00;
    enter_byte_s = 1'b0;
    byte_idx_s   = 7'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_PRE;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          addr_d  = CFG_PRE;
        end else begin
          state_d = IDLE;
        end
      end
      RD_PRE: begin
        pre_d   = mem_rdata;
        state_d = RD_TAP;
        rd_en_d = 1'b1;
        addr_d  = CFG_TAP;
      end
      RD_TAP: begin
        tap_d   = mem_rdata;
        state_d = RD_SEED;
        rd_en_d = 1'b1;
        addr_d  = CFG_SEED;
      end
      RD_SEED: begin
        i_d          = 7'd0;
        enter_byte_s = 1'b1;
        byte_idx_s   = 7'd0;
      end
      SRC: begin
        // Keystream does not move on a SRC edge, so lfsr_nx_s equals lfsr_s.
        src_d   = mem_rdata;
        state_d = WR;
        wr_en_d = 1'b1;
        addr_d  = OUT_BASE + {1'b0, i_q};
        wdata_d = mem_rdata ^ lfsr_nx_s;
      end
      WR: begin
        i_d = i_q + 7'd1;
        if (i_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          enter_byte_s = 1'b1;
          byte_idx_s   = i_q + 7'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Start of a byte: read the message byte, or write padding directly.
    if (enter_byte_s) begin
      if (is_msg_byte(byte_idx_s, pre_q)) begin
        state_d = SRC;
        rd_en_d = 1'b1;
        addr_d  = MSG_BASE + ({1'b0, byte_idx_s} - pre_q);
      end else begin
        state_d = WR;
        src_d   = PAD;
        wr_en_d = 1'b1;
        addr_d  = OUT_BASE + {1'b0, byte_idx_s};
        wdata_d = PAD ^ lfsr_nx_s;
      end
    end else begin
      byte_idx_s = byte_idx_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 7'd0;
      pre_q   <= 8'h00;
      tap_q   <= 8'h00;
      src_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 8'h00;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pre_q   <= pre_d;
      tap_q   <= tap_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  // A write pending at a reset edge must not land in memory.
  assign mem_wr_en = wr_en_q & ~reset;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lfsr_crypt_sequencer.sv
module tb_lfsr_crypt_sequencer;
  import crypt_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done;
  logic [7:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_rdata, mem_wdata;

  logic [7:0]  mem [0:255];
  logic [7:0]  rd_log [$];
  logic [15:0] wr_log [$];
  int          both_hi = 0;

  int checks = 0;
  int errors = 0;

  lfsr_crypt_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Bus monitor: logs every read address and every write, flags overlap.
  always @(posedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_addr);
    if (mem_wr_en) wr_log.push_back({mem_addr, mem_wdata});
    if (mem_rd_en && mem_wr_en) both_hi = both_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_msg_str(input string s);
    for (int k = 0; k < 61; k++) mem[k] = (k < s.len()) ? s[k] : 8'h20;
  endtask

  task automatic load_msg_rand();
    for (int k = 0; k < 61; k++) mem[k] = 8'($urandom_range(32, 126));
  endtask

  // Runs one job and compares against a model built from the job rules.
  // hold: start stays high for this many cycles after acceptance;
  // pulse_at: an extra one-cycle start pulse at that cycle (-1 for none).
  task automatic run_job(input string tag, input logic [7:0] pre, input logic [7:0] tap,
                         input logic [7:0] seed, input int hold, input int pulse_at,
                         output int ws);
    logic [7:0] plain [64];
    logic [7:0] exp_rd [$];
    logic [7:0] key;
    int rs, cycles, nrd;
    mem[61] = pre; mem[62] = tap; mem[63] = seed;
    exp_rd = {8'd61, 8'd62, 8'd63};
    for (int k = 0; k < 64; k++) begin
      if (k < int'(pre)) plain[k] = 8'h20;
      else if (k - int'(pre) < 61) begin
        plain[k] = mem[k - int'(pre)];
        exp_rd.push_back(8'(k - int'(pre)));
      end else plain[k] = 8'h20;
    end
    nrd = exp_rd.size() - 3;
    rs = rd_log.size();
    ws = wr_log.size();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_on"}, busy, 1'b1);
    check({tag, "_done_clr"}, done, 1'b0);
    start = (hold > 0);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); cycles++; #1;
      if (done) break;
      start = (cycles < hold) || (cycles == pulse_at);
    end
    start = 1'b0;
    check({tag, "_latency"}, cycles, 3 + 64 + nrd + 1);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_nwr"}, wr_log.size() - ws, 64);
    check({tag, "_nrd"}, rd_log.size() - rs, exp_rd.size());
    key = seed;
    for (int k = 0; k < 64; k++) begin
      if (ws + k < wr_log.size())
        check($sformatf("%s_wr%0d", tag, k), wr_log[ws + k], {8'(64 + k), plain[k] ^ key});
      key = lfsr_next(key, tap);
    end
    for (int k = 0; k < exp_rd.size(); k++) begin
      if (rs + k < rd_log.size())
        check($sformatf("%s_rd%0d", tag, k), rd_log[rs + k], exp_rd[k]);
    end
  endtask

  initial begin
    int ws, ws2, ws_r;
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reference example
    load_msg_str("Mr. Watson, come here. I want to see you.");
    run_job("t1", 8'd9, 8'hd4, 8'h41, 0, -1, ws);
    check("t1_done", done, 1'b1);
    check("t1_b0", wr_log[ws][7:0], 8'h61);
    check("t1_b1", wr_log[ws + 1][7:0], 8'hA3);

    // 2: full-length message, no leading spaces
    load_msg_rand();
    run_job("t2", 8'd0, 8'hb8, 8'h5a, 0, -1, ws);

    // 3: pre beyond output length -> pure padding
    run_job("t3", 8'd70, 8'h8e, 8'hc3, 0, -1, ws);

    // 4: zero seed -> plaintext passes through unchanged
    load_msg_str("Plain text survives a zero seed.");
    run_job("t4", 8'd12, 8'hb8, 8'h00, 0, -1, ws);
    check("t4_first_msg", wr_log[ws + 12][7:0], 8'h50);

    // 5: reset on the 20th cycle of a job
    mem[61] = 8'd5; mem[62] = 8'hd4; mem[63] = 8'h77;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    ws_r = wr_log.size();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_wr", wr_log.size() - ws_r, 0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_rd_en", mem_rd_en, 1'b0);
    run_job("t5b", 8'd5, 8'hd4, 8'h77, 0, -1, ws);

    // 6: start held through the job plus a pulse while busy -> one job
    load_msg_rand();
    run_job("t6", 8'd20, 8'he1, 8'h3c, 200, -1, ws);
    run_job("t6p", 8'd30, 8'h96, 8'h19, 40, 90, ws);
    ws2 = wr_log.size();
    repeat (5) @(posedge clk);
    #1;
    check("t6_idle_nowr", wr_log.size() - ws2, 0);
    check("t6_done_sticky", done, 1'b1);
    check("t6_busy_idle", busy, 1'b0);
    run_job("t6r", 8'd30, 8'h96, 8'h19, 0, -1, ws);

    // Randomised jobs
    for (int j = 0; j < 4; j++) begin
      load_msg_rand();
      run_job($sformatf("rnd%0d", j), 8'($urandom_range(0, 80)), 8'($urandom),
              8'($urandom), 0, -1, ws);
    end

    check("rd_wr_overlap", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
